// File: rtl/continuous_monitoring_system_pkg.sv
// Shared constants for the continuous monitoring system: RISC-V encodings
// used by the trace monitors and the trace class indices.
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH = 32;

  localparam logic [6:0]  BRANCH_OPCODE   = 7'b1100011;
  localparam logic [6:0]  JAL_OPCODE      = 7'b1101111;
  localparam logic [6:0]  JALR_OPCODE     = 7'b1100111;
  localparam logic [31:0] WFI_INSTRUCTION = 32'h10500073;

  localparam logic [31:0] RET_INSTRUCTION   = 32'h00008067;
  localparam logic [15:0] C_RET_INSTRUCTION = 16'h8082;

  // Compressed quadrants and funct fields for control-flow instructions
  localparam logic [1:0] C_QUADRANT_1   = 2'b01;
  localparam logic [1:0] C_QUADRANT_2   = 2'b10;
  localparam logic [2:0] C_J_FUNCT3     = 3'b101;
  localparam logic [2:0] C_JAL_FUNCT3   = 3'b001;
  localparam logic [2:0] C_BEQZ_FUNCT3  = 3'b110;
  localparam logic [2:0] C_BNEZ_FUNCT3  = 3'b111;
  localparam logic [3:0] C_JR_FUNCT4    = 4'b1000;
  localparam logic [3:0] C_JALR_FUNCT4  = 4'b1001;

  localparam int TRACE_CLASS_BRANCH = 0;
  localparam int TRACE_CLASS_JUMP   = 1;
  localparam int TRACE_CLASS_RETURN = 2;
  localparam int TRACE_CLASS_WFI    = 3;
  localparam int TRACE_NUM_CLASSES  = 4;

  typedef logic [TRACE_NUM_CLASSES-1:0] trace_class_t;

endpackage

// File: rtl/trace_instr_classifier.sv
// Combinational instruction classifier: maps an instruction word to a
// one-hot trace class (branch, jump, return, wfi).
module trace_instr_classifier
  import continuous_monitoring_system_pkg::*;
#(
  parameter int INSTR_WIDTH = RISC_V_INSTRUCTION_WIDTH
) (
  input  logic [INSTR_WIDTH-1:0]       instr,
  output logic [TRACE_NUM_CLASSES-1:0] instr_class
);

  logic [31:0] word;
  logic        is_compressed;
  logic        is_q1;
  logic        is_q2;
  logic        is_ret;
  logic        is_jump;
  logic        is_branch;
  logic        is_wfi;
  logic        is_c_jr_form;

  assign word          = instr[31:0];
  assign is_compressed = (word[1:0] != 2'b11);
  assign is_q1         = (word[1:0] == C_QUADRANT_1);
  assign is_q2         = (word[1:0] == C_QUADRANT_2);

  // C.JR / C.JALR need rs1 != 0 and rs2 == 0; otherwise the encoding is C.MV/C.ADD/C.EBREAK
  assign is_c_jr_form = is_q2
                      && ((word[15:12] == C_JR_FUNCT4) || (word[15:12] == C_JALR_FUNCT4))
                      && (word[11:7] != 5'd0) && (word[6:2] == 5'd0);

  assign is_ret = (word == RET_INSTRUCTION) || (word[15:0] == C_RET_INSTRUCTION);

  assign is_jump = (!is_compressed && ((word[6:0] == JAL_OPCODE) || (word[6:0] == JALR_OPCODE)))
                || (is_q1 && ((word[15:13] == C_J_FUNCT3) || (word[15:13] == C_JAL_FUNCT3)))
                || is_c_jr_form;

  assign is_branch = (!is_compressed && (word[6:0] == BRANCH_OPCODE))
                  || (is_q1 && ((word[15:13] == C_BEQZ_FUNCT3) || (word[15:13] == C_BNEZ_FUNCT3)));

  assign is_wfi = (word == WFI_INSTRUCTION);

  always_comb begin
    instr_class                     = '0;
    instr_class[TRACE_CLASS_BRANCH] = is_branch;
    instr_class[TRACE_CLASS_JUMP]   = is_jump && !is_ret;
    instr_class[TRACE_CLASS_RETURN] = is_ret;
    instr_class[TRACE_CLASS_WFI]    = is_wfi;
  end

endmodule

// File: rtl/trace_event_filter.sv
// Trace event filter: stages each valid instruction, keeps it on an enabled
// class hit or inside the trailing window, and counts kept/dropped decisions.
module trace_event_filter
  import continuous_monitoring_system_pkg::*;
#(
  parameter int INSTR_WIDTH = RISC_V_INSTRUCTION_WIDTH,
  parameter int ADDR_WIDTH  = 64,
  parameter int TRAIL_WIDTH = 4,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_valid,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic [INSTR_WIDTH-1:0] next_instr,
  input  logic [3:0]             cfg_class_en,
  input  logic [TRAIL_WIDTH-1:0] cfg_trail_len,
  input  logic                   cfg_range_en,
  input  logic [ADDR_WIDTH-1:0]  cfg_range_lo,
  input  logic [ADDR_WIDTH-1:0]  cfg_range_hi,
  input  logic                   stat_clear,
  output logic                   drop_instr,
  output logic [4:0]             keep_reason,
  output logic [STAT_WIDTH-1:0]  kept_count,
  output logic [STAT_WIDTH-1:0]  dropped_count
);

  localparam logic [TRAIL_WIDTH-1:0] TRAIL_ONE = 1;
  localparam logic [STAT_WIDTH-1:0]  STAT_ONE  = 1;

  logic [TRACE_NUM_CLASSES-1:0] instr_class;
  logic [TRACE_NUM_CLASSES-1:0] class_q;
  logic                         in_range;
  logic                         in_range_q;
  logic                         stage_valid_q;
  logic [TRAIL_WIDTH-1:0]       trail_cnt_q;
  logic [STAT_WIDTH-1:0]        kept_q;
  logic [STAT_WIDTH-1:0]        dropped_q;
  logic                         hit;
  logic                         trail;
  logic                         keep;

  trace_instr_classifier #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_classifier (
    .instr       (next_instr),
    .instr_class (instr_class)
  );

  // An inverted range (lo > hi) naturally matches nothing
  assign in_range = !cfg_range_en || ((pc >= cfg_range_lo) && (pc <= cfg_range_hi));

  assign hit   = (class_q != '0) && in_range_q;
  assign trail = (trail_cnt_q != '0) && in_range_q;
  assign keep  = stage_valid_q && (hit || trail);

  assign drop_instr    = !keep;
  assign keep_reason   = {trail && !hit, hit ? class_q : 4'b0};
  assign kept_count    = kept_q;
  assign dropped_count = dropped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      class_q       <= '0;
      in_range_q    <= 1'b0;
      trail_cnt_q   <= '0;
    end else if (pc_valid) begin
      stage_valid_q <= 1'b1;
      class_q       <= instr_class & cfg_class_en;
      in_range_q    <= in_range;
      // The window opens after the event itself, so reload from the outgoing stage
      if (hit) begin
        trail_cnt_q <= cfg_trail_len;
      end else if (trail_cnt_q != '0) begin
        trail_cnt_q <= trail_cnt_q - TRAIL_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kept_q    <= '0;
      dropped_q <= '0;
    end else if (stat_clear) begin
      kept_q    <= '0;
      dropped_q <= '0;
    end else if (pc_valid && stage_valid_q) begin
      if (keep) begin
        if (kept_q != '1) kept_q <= kept_q + STAT_ONE;
      end else begin
        if (dropped_q != '1) dropped_q <= dropped_q + STAT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_trace_event_filter.sv
// Directed bench for trace_event_filter; 4-bit statistics counters make
// saturation reachable in a few dozen instructions.
module tb_trace_event_filter;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] BEQ   = 32'h00000063;
  localparam logic [31:0] JAL   = 32'h000000EF;
  localparam logic [31:0] CBEQZ = 32'h0000C001;
  localparam logic [31:0] RET   = 32'h00008067;
  localparam logic [31:0] CRET  = 32'h00008082;
  localparam logic [31:0] WFI   = 32'h10500073;
  localparam logic [31:0] CJ    = 32'h0000A001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid;
  logic [63:0] pc;
  logic [31:0] next_instr;
  logic [3:0]  cfg_class_en;
  logic [3:0]  cfg_trail_len;
  logic        cfg_range_en;
  logic [63:0] cfg_range_lo;
  logic [63:0] cfg_range_hi;
  logic        stat_clear;
  logic        drop_instr;
  logic [4:0]  keep_reason;
  logic [3:0]  kept_count;
  logic [3:0]  dropped_count;

  int total = 0;
  int fails = 0;

  trace_event_filter #(
    .INSTR_WIDTH (32),
    .ADDR_WIDTH  (64),
    .TRAIL_WIDTH (4),
    .STAT_WIDTH  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_valid      (pc_valid),
    .pc            (pc),
    .next_instr    (next_instr),
    .cfg_class_en  (cfg_class_en),
    .cfg_trail_len (cfg_trail_len),
    .cfg_range_en  (cfg_range_en),
    .cfg_range_lo  (cfg_range_lo),
    .cfg_range_hi  (cfg_range_hi),
    .stat_clear    (stat_clear),
    .drop_instr    (drop_instr),
    .keep_reason   (keep_reason),
    .kept_count    (kept_count),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pc_valid cycle; returns at the following falling edge
  task automatic issue(input logic [31:0] instr, input logic [63:0] addr = 64'h0,
                       input logic clr = 1'b0);
    @(negedge clk);
    next_instr = instr;
    pc         = addr;
    stat_clear = clr;
    pc_valid   = 1'b1;
    @(negedge clk);
    pc_valid   = 1'b0;
    stat_clear = 1'b0;
  endtask

  task automatic chk_dec(input string tag, input logic exp_drop, input logic [4:0] exp_reason);
    chk({tag, "_drop"}, 64'(drop_instr), 64'(exp_drop));
    chk({tag, "_reason"}, 64'(keep_reason), 64'(exp_reason));
  endtask

  initial begin
    rst_n         = 1'b0;
    pc_valid      = 1'b0;
    pc            = '0;
    next_instr    = NOP;
    cfg_class_en  = 4'hF;
    cfg_trail_len = 4'd1;
    cfg_range_en  = 1'b0;
    cfg_range_lo  = '0;
    cfg_range_hi  = '0;
    stat_clear    = 1'b0;

    #12;
    chk_dec("reset", 1'b1, 5'h00);
    chk("reset_kept", 64'(kept_count), 64'd0);
    chk("reset_dropped", 64'(dropped_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Trailing window of one
    issue(NOP); chk_dec("t1_nop0", 1'b1, 5'h00);
    issue(BEQ); chk_dec("t1_beq", 1'b0, 5'h01);
    issue(NOP); chk_dec("t1_trail", 1'b0, 5'h10);
    issue(NOP); chk_dec("t1_after", 1'b1, 5'h00);
    chk("t1_kept", 64'(kept_count), 64'd2);
    chk("t1_dropped", 64'(dropped_count), 64'd1);

    // Window of three, then restart by an event inside the window
    cfg_trail_len = 4'd3;
    issue(JAL); chk_dec("t2_jal", 1'b0, 5'h02);
    issue(NOP); chk_dec("t2_n1", 1'b0, 5'h10);
    issue(NOP); chk_dec("t2_n2", 1'b0, 5'h10);
    issue(NOP); chk_dec("t2_n3", 1'b0, 5'h10);
    issue(NOP); chk_dec("t2_n4", 1'b1, 5'h00);
    issue(NOP); chk_dec("t2_n5", 1'b1, 5'h00);
    chk("t2_kept", 64'(kept_count), 64'd6);
    chk("t2_dropped", 64'(dropped_count), 64'd3);
    issue(JAL);   chk_dec("t2r_jal", 1'b0, 5'h02);
    issue(NOP);   chk_dec("t2r_n1", 1'b0, 5'h10);
    issue(CBEQZ); chk_dec("t2r_cbeqz", 1'b0, 5'h01);
    issue(NOP);   chk_dec("t2r_n2", 1'b0, 5'h10);
    issue(NOP);   chk_dec("t2r_n3", 1'b0, 5'h10);
    issue(NOP);   chk_dec("t2r_n4", 1'b0, 5'h10);
    issue(NOP);   chk_dec("t2r_n5", 1'b1, 5'h00);

    issue(NOP, 64'h0, 1'b1);
    chk("clr_kept", 64'(kept_count), 64'd0);
    chk("clr_dropped", 64'(dropped_count), 64'd0);

    // Classification
    cfg_trail_len = 4'd0;
    issue(RET);  chk_dec("cls_ret", 1'b0, 5'h04);
    issue(CRET); chk_dec("cls_cret", 1'b0, 5'h04);
    issue(WFI);  chk_dec("cls_wfi", 1'b0, 5'h08);
    issue(CJ);   chk_dec("cls_cj", 1'b0, 5'h02);
    cfg_class_en = 4'b1011;
    issue(RET);  chk_dec("cls_ret_dis", 1'b1, 5'h00);
    cfg_class_en = 4'hF;
    @(negedge clk);
    chk_dec("cfg_no_retro", 1'b1, 5'h00);

    // PC range gating
    cfg_range_en = 1'b1;
    cfg_range_lo = 64'h8000_0000;
    cfg_range_hi = 64'h8000_00FF;
    issue(BEQ, 64'h8000_0100); chk_dec("rng_above", 1'b1, 5'h00);
    issue(BEQ, 64'h8000_00FF); chk_dec("rng_hi", 1'b0, 5'h01);
    issue(BEQ, 64'h8000_0000); chk_dec("rng_lo", 1'b0, 5'h01);
    issue(BEQ, 64'h7FFF_FFFF); chk_dec("rng_below", 1'b1, 5'h00);
    cfg_range_lo = 64'h8000_0100;
    issue(BEQ, 64'h8000_0100); chk_dec("rng_inv_a", 1'b1, 5'h00);
    issue(BEQ, 64'h8000_00FF); chk_dec("rng_inv_b", 1'b1, 5'h00);
    cfg_range_en = 1'b0;

    // Hold, clear and saturation
    issue(NOP, 64'h0, 1'b1);
    issue(BEQ);
    repeat (10) @(negedge clk);
    chk_dec("hold", 1'b0, 5'h01);
    chk("hold_kept", 64'(kept_count), 64'd0);
    chk("hold_dropped", 64'(dropped_count), 64'd1);
    for (int i = 0; i < 20; i++) issue(NOP);
    chk("sat_dropped", 64'(dropped_count), 64'd15);
    chk("sat_kept_mid", 64'(kept_count), 64'd1);
    for (int i = 0; i < 20; i++) issue(BEQ);
    chk("sat_kept", 64'(kept_count), 64'd15);
    chk("sat_dropped_hold", 64'(dropped_count), 64'd15);

    // Asynchronous reset in the middle of a window
    cfg_trail_len = 4'd3;
    issue(BEQ);
    issue(NOP);
    issue(NOP);
    chk_dec("pre_rst", 1'b0, 5'h10);
    #2 rst_n = 1'b0;
    #1;
    chk_dec("async_rst", 1'b1, 5'h00);
    chk("async_rst_kept", 64'(kept_count), 64'd0);
    chk("async_rst_dropped", 64'(dropped_count), 64'd0);
    #1 rst_n = 1'b1;
    issue(NOP); chk_dec("post_rst", 1'b1, 5'h00);
    chk("post_rst_dropped", 64'(dropped_count), 64'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/trace_event_filter.md
Name: trace_event_filter

Overview:
Parametrised successor to the single-shot trace filter in the continuous monitoring system. It sits between the CPU trace tap and the trace storage/transfer path. Each `pc_valid` cycle it classifies the next instruction as branch, jump, return or WFI. It then decides whether the trace entry is kept, using:
- runtime per-class enables
- a runtime-programmable trailing window of N instructions after each event
- an optional inclusive PC address range

It also keeps saturating kept/dropped statistics counters.

Parameters:
- `INSTR_WIDTH`, `RISC_V_INSTRUCTION_WIDTH`, width of `next_instr`.
- `ADDR_WIDTH`, 64, PC width.
- `TRAIL_WIDTH`, 4, width of the trailing-window count; maximum window is 2^TRAIL_WIDTH-1.
- `STAT_WIDTH`, 32, width of each statistics counter.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `pc_valid`  in  1  `pc`/`next_instr` valid this cycle
- `pc`  in  ADDR_WIDTH  address of `next_instr`
- `next_instr`  in  INSTR_WIDTH  instruction word; compressed instructions occupy [15:0]
- `cfg_class_en`  in  4  per-class enable: [0] branch, [1] jump, [2] return, [3] wfi
- `cfg_trail_len`  in  TRAIL_WIDTH  number of instructions kept after an event; 0 = none
- `cfg_range_en`  in  1  enable PC range gating
- `cfg_range_lo`  in  ADDR_WIDTH  inclusive lower PC bound
- `cfg_range_hi`  in  ADDR_WIDTH  inclusive upper PC bound
- `stat_clear`  in  1  synchronous clear of both statistics counters
- `drop_instr`  out  1  1 = drop the currently staged instruction
- `keep_reason`  out  5  staged reason: [3:0] class hit, [4] trailing-window keep
- `kept_count`  out  STAT_WIDTH  saturating count of kept decisions
- `dropped_count`  out  STAT_WIDTH  saturating count of dropped decisions

Behaviour:
- **Reset.** Asynchronous, `rst_n` = 0. Clears all registers:
  - `stage_valid_q` = 0, `class_q` = 0, `in_range_q` = 0, `trail_cnt_q` = 0
  - both counters = 0
  - outputs: `drop_instr` = 1, `keep_reason` = 0, `kept_count` = 0, `dropped_count` = 0
- **Update rule.** State updates only on `clk` rising edges with `pc_valid` = 1. With `pc_valid` = 0 all state holds, so the decision is stable.
- **Classification.** Combinational on `next_instr`.
  - return: `next_instr` == 32'h00008067, or [15:0] == 16'h8082.
  - jump: JAL/JALR/C.JAL/C.JALR/C.J/C.JR opcodes, excluding returns.
  - branch: BRANCH_OPCODE, or compressed C.BEQZ/C.BNEZ.
  - wfi: `next_instr` == WFI_INSTRUCTION.
  - At most one class bit is set per instruction.
- **Range test.** `in_range` = !`cfg_range_en` || (`cfg_range_lo` <= `pc` <= `cfg_range_hi`), unsigned comparison. If lo > hi, nothing is in range while enabled.
- **Capture on `pc_valid`.**
  - `class_q` <= class & `cfg_class_en`
  - `in_range_q` <= `in_range`
  - `stage_valid_q` <= 1
- **Trailing counter on `pc_valid`.**
  - If the outgoing `class_q` != 0 and `in_range_q`: `trail_cnt_q` <= `cfg_trail_len` (reload, no accumulation).
  - Else if `trail_cnt_q` != 0: decrement.
  - Else hold 0.
  - Effect: `cfg_trail_len` = N keeps exactly N staged instructions after an event. An event inside a window restarts the window at N.
- **Decision, combinational from registers.**
  - `hit` = (`class_q` != 0) && `in_range_q`
  - `trail` = (`trail_cnt_q` != 0) && `in_range_q`
  - `drop_instr` = !`stage_valid_q` || !(`hit` || `trail`)
  - `keep_reason` = {`trail` && !`hit`, `hit` ? `class_q` : 4'b0}
- **Latency.** An instruction presented with `pc_valid` at edge k is decided during cycle k+1, until the next `pc_valid`.
- **Statistics.**
  - On `pc_valid` with `stage_valid_q` = 1, the outgoing decision increments `kept_count` or `dropped_count`.
  - Counters saturate at all-ones.
  - `stat_clear` has priority over an increment in the same cycle.
- **Configuration timing.** Config inputs are sampled only on `pc_valid` edges. A change affects the next captured instruction; it never retroactively alters the staged decision. `cfg_class_en` = 0 with `cfg_trail_len` = 0 drops everything.
- **Reset mid-window.** The counter clears immediately and no trailing keep survives.

Decomposition:
- **Package `continuous_monitoring_system_pkg`.** Add:
  - RET_INSTRUCTION (32'h00008067)
  - C_RET_INSTRUCTION (16'h8082)
  - C_J_FUNCT3 and C_JR encodings
  - class index constants TRACE_CLASS_BRANCH=0, TRACE_CLASS_JUMP=1, TRACE_CLASS_RETURN=2, TRACE_CLASS_WFI=3, TRACE_NUM_CLASSES=4
- Existing opcode constants are reused.
- **Sub-module `trace_instr_classifier`.** Purely combinational `next_instr` → 4-bit one-hot class, reusable by other monitors.

Test Plan:
1. Reset, `cfg_class_en` = 4'hF, `cfg_trail_len` = 1, `cfg_range_en` = 0. Drive 0x00000013 then 0x00000063 then 0x00000013 then 0x00000013 → drop = 1, 0, 0 (trail, `keep_reason` = 5'h10), 1; `kept_count` = 2 after the next `pc_valid`.
2. `cfg_trail_len` = 3. Drive 0x000000EF followed by 5 NOPs → keep, keep, keep, keep, drop, drop. Insert 0xC001 at NOP #2 → window restarts, and 3 further NOPs are kept.
3. Classification check → `keep_reason`[3:0] values:
   - 0x00008067 → 4'b0100
   - 16'h8082 → 4'b0100 (not jump)
   - 0x10500073 → 4'b1000
   - 0xA001 → 4'b0010
   - With `cfg_class_en` = 4'b1011, 0x00008067 is dropped.
4. `cfg_range_en` = 1, lo = 0x8000_0000, hi = 0x8000_00FF. Branch at PC 0x8000_0100 → dropped; at 0x8000_00FF → kept; lo > hi → all dropped.
5. Hold `pc_valid` low 10 cycles after a branch → `drop_instr` stays 0 and counters are unchanged. Assert `stat_clear` with `pc_valid` → counters read 0 next cycle. Force the counters near all-ones → they saturate and do not wrap.
6. Pulse `rst_n` low asynchronously mid-window (`trail_cnt_q` = 2) → immediately `drop_instr` = 1, `keep_reason` = 0, counters = 0. The first NOP after release is dropped.
